// File: rtl/qrisc_pkg.sv
// Shared qrisc32 definitions: machine word type and byte-address to word-index helper.
package qrisc_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [29:0] word_index(input word_t byte_addr);
    return 30'(byte_addr / WORD_BYTES);
  endfunction

endpackage

// File: rtl/qrisc_mem.sv
// Word-organised RAM model for the qrisc32 instruction/data master ports, with a sticky
// "fetch past end of program" flag. Define QRISC_MEM_TRACE_EN to compile access tracing.
module qrisc_mem
  import qrisc_pkg::*;
#(
  parameter int size      = 256,
  parameter int adr_limit = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] add_r,
  input  logic        rd,
  output logic [31:0] data_r,
  input  logic [31:0] add_w,
  input  logic [31:0] data_w,
  input  logic        wr,
  output logic        req,
  input  logic        stop_enable,
  output logic        stop_active,
  input  logic        verbose
);

  localparam int unsigned AW      = (size > 1) ? $clog2(size) : 1;
  localparam logic [31:0] SIZE_W  = 32'(size);
  localparam logic [31:0] LIMIT_W = 32'(adr_limit);

  word_t       sram [0:size-1];
  word_t       data_q, data_d;
  logic        stop_q, stop_d;
  logic        frozen;
  logic [29:0] idx_r, idx_w;
  logic        rd_in_range, wr_in_range;
  logic        rd_ok, wr_ok;

  always_comb begin
    idx_r       = word_index(add_r);
    idx_w       = word_index(add_w);
    rd_in_range = ({2'b00, idx_r} < SIZE_W);
    wr_in_range = ({2'b00, idx_w} < SIZE_W);
    frozen      = stop_q & stop_enable;
    rd_ok       = rd & ~frozen;
    wr_ok       = wr & ~frozen & wr_in_range;
  end

  // Stop detection looks at the full 30-bit index, so it also fires when frozen reads are ignored.
  always_comb begin
    data_d = data_q;
    stop_d = stop_q | (rd & ({2'b00, idx_r} >= LIMIT_W));
    if (rd_ok) begin
      data_d = rd_in_range ? sram[idx_r[AW-1:0]] : '0;
    end
  end

  // Array lives in the reset process so a write coinciding with reset assertion is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      stop_q <= 1'b0;
    end else begin
      data_q <= data_d;
      stop_q <= stop_d;
      if (wr_ok) begin
        sram[idx_w[AW-1:0]] <= data_w;
      end
`ifdef QRISC_MEM_TRACE_EN
      if (verbose && rd_ok)
        $display("%0t qrisc_mem R addr=%h data=%h", $time, add_r, data_d);
      if (verbose && wr && !frozen)
        $display("%0t qrisc_mem W addr=%h data=%h", $time, add_w, data_w);
      if (stop_d && !stop_q)
        $display("%0t qrisc_mem stop: fetch past limit at addr=%h", $time, add_r);
`endif
    end
  end

`ifndef QRISC_MEM_TRACE_EN
  logic unused_ok;
  assign unused_ok = verbose;
`endif

  assign data_r      = data_q;
  assign stop_active = stop_q;
  assign req         = frozen;

endmodule

// File: tb/tb_qrisc_mem.sv
// Directed self-checking bench for qrisc_mem (size=10, adr_limit=93).
module tb_qrisc_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] add_r, add_w, data_w;
  logic        rd, wr, stop_enable, verbose;
  logic [31:0] data_r;
  logic        req, stop_active;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_mem [0:9];

  qrisc_mem #(.size(10), .adr_limit(93)) dut (
    .clk(clk), .reset_n(reset_n),
    .add_r(add_r), .rd(rd), .data_r(data_r),
    .add_w(add_w), .data_w(data_w), .wr(wr),
    .req(req), .stop_enable(stop_enable), .stop_active(stop_active),
    .verbose(verbose)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 10; i++) check(tag, dut.sram[i], exp_mem[i]);
  endtask

  initial begin
    reset_n = 1'b0; rd = 1'b0; wr = 1'b0; add_r = '0; add_w = '0; data_w = '0;
    stop_enable = 1'b0; verbose = 1'b0;
    for (int i = 0; i < 10; i++) exp_mem[i] = 32'hA000_0000 + 32'(i);
    exp_mem[3] = 32'hDEAD_BEEF;
    exp_mem[2] = 32'd5;
    for (int i = 0; i < 10; i++) dut.sram[i] = exp_mem[i];
    tick();
    check("reset_data_r", data_r, 32'h0);
    check("reset_stop", {31'b0, stop_active}, 32'h0);
    check("reset_req", {31'b0, req}, 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // write / readback
    rd = 1'b1; add_r = 32'h0C; tick();
    check("read_preload", data_r, 32'hDEAD_BEEF);
    rd = 1'b0; wr = 1'b1; add_w = 32'h0C; data_w = 32'h1234; tick();
    exp_mem[3] = 32'h1234;
    check("hold_no_rd", data_r, 32'hDEAD_BEEF);
    wr = 1'b0; rd = 1'b1; tick();
    check("readback", data_r, 32'h1234);

    // read-before-write collision
    wr = 1'b1; add_w = 32'h08; data_w = 32'd9; add_r = 32'h08; tick();
    exp_mem[2] = 32'd9;
    check("collision_old", data_r, 32'd5);
    wr = 1'b0; tick();
    check("collision_new", data_r, 32'd9);

    // range
    add_r = 32'h28; tick();
    check("oor_read", data_r, 32'h0);
    rd = 1'b0; wr = 1'b1; add_w = 32'h28; data_w = 32'hFFFF_FFFF; tick();
    wr = 1'b0;
    check_mem("oor_write");
    rd = 1'b1; add_r = 32'h27; tick();
    check("last_word_ignore_low_bits", data_r, exp_mem[9]);

    // stop detection, not frozen
    for (int i = 0; i < 93; i++) begin
      add_r = 32'(i) << 2; tick();
      check("no_stop_below_limit", {31'b0, stop_active}, 32'h0);
    end
    add_r = 32'd4000; tick();
    check("stop_set", {31'b0, stop_active}, 32'h1);
    check("req_no_enable", {31'b0, req}, 32'h0);
    add_r = 32'h0C; tick();
    check("stop_sticky", {31'b0, stop_active}, 32'h1);
    check("read_after_stop", data_r, 32'h1234);
    rd = 1'b0; wr = 1'b1; add_w = 32'h10; data_w = 32'h77; tick();
    exp_mem[4] = 32'h77;
    wr = 1'b0; rd = 1'b1; add_r = 32'h10; tick();
    check("write_after_stop", data_r, 32'h77);

    // asynchronous reset mid-cycle
    reset_n = 1'b0; #1;
    check("areset_data_r", data_r, 32'h0);
    check("areset_stop", {31'b0, stop_active}, 32'h0);
    check("areset_req", {31'b0, req}, 32'h0);
    check_mem("reset_keeps_sram");
    @(negedge clk); reset_n = 1'b1;

    // freeze
    stop_enable = 1'b1; add_r = 32'h0C; tick();
    check("pre_freeze_read", data_r, 32'h1234);
    add_r = 32'd4000; tick();
    check("freeze_stop", {31'b0, stop_active}, 32'h1);
    check("freeze_req", {31'b0, req}, 32'h1);
    check("freeze_oor_data", data_r, 32'h0);
    add_r = 32'h0C; wr = 1'b1; add_w = 32'h14; data_w = 32'h55; tick();
    check("frozen_hold", data_r, 32'h0);
    wr = 1'b0;
    check_mem("frozen_no_write");
    stop_enable = 1'b0; #1;
    check("unfreeze_req", {31'b0, req}, 32'h0);
    add_r = 32'h14; tick();
    check("unfrozen_read", data_r, exp_mem[5]);

    // write coinciding with reset is lost
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; add_w = 32'h18; data_w = 32'hBAD0_0000; reset_n = 1'b0;
    tick();
    wr = 1'b0;
    check_mem("write_during_reset");
    @(negedge clk); reset_n = 1'b1;
    rd = 1'b1; add_r = 32'h18; tick();
    check("read_after_reset", data_r, exp_mem[6]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
